// File: rtl/serial_sub_sequencer.sv
// Bit-serial subtract controller: drives an external 1-bit subtractor cell LSB-first,
// chains the borrow through a register and assembles a WIDTH-bit difference.
module serial_sub_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             overflow,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_bin,
  input  logic             cell_diff,
  input  logic             cell_bout
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    borrow_d     = borrow_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    busy         = 1'b0;
    done         = 1'b0;
    cell_a       = 1'b0;
    cell_b       = 1'b0;
    cell_bin     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        done    = (state_q == StDone);
        state_d = StIdle;
        if (start) begin
          a_sh_d   = op_a;
          b_sh_d   = op_b;
          borrow_d = bin_init;
          a_msb_d  = op_a[WIDTH-1];
          b_msb_d  = op_b[WIDTH-1];
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        busy     = 1'b1;
        cell_a   = a_sh_q[0];
        cell_b   = b_sh_q[0];
        cell_bin = borrow_q;
        // New diff bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_sh_d = (res_sh_q >> 1) | {cell_diff, {(WIDTH-1){1'b0}}};
        borrow_d = cell_bout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          result_d     = res_sh_d;
          borrow_out_d = cell_bout;
          overflow_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_diff);
          cnt_d        = '0;
          state_d      = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      borrow_q     <= borrow_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign result     = result_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Directed bench for serial_sub_sequencer with a behavioural subtractor cell attached.
module tb_serial_sub_sequencer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             bin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             overflow;
  logic             cell_a;
  logic             cell_b;
  logic             cell_bin;
  logic             cell_diff;
  logic             cell_bout;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] last_res;
  logic             last_bout;
  logic             last_ovf;

  serial_sub_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .bin_init   (bin_init),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .cell_a     (cell_a),
    .cell_b     (cell_b),
    .cell_bin   (cell_bin),
    .cell_diff  (cell_diff),
    .cell_bout  (cell_bout)
  );

  // Full subtractor cell
  assign cell_diff = cell_a ^ cell_b ^ cell_bin;
  assign cell_bout = (~cell_a & cell_b) | (~cell_a & cell_bin) | (cell_b & cell_bin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cells"}, {29'd0, cell_a, cell_b, cell_bin}, 32'd0);
  endtask

  // Called at a negedge: presents an operation to be sampled on the next rising edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    op_a     = a;
    op_b     = b;
    bin_init = bi;
    start    = 1'b1;
  endtask

  // Follows one op from its accepting edge through the DONE cycle; ends at the DONE negedge.
  task automatic run_check(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic bi, input logic [WIDTH-1:0] exp_res, input logic exp_bout,
                           input logic exp_ovf, input logic hold_start);
    logic bw;
    bw = bi;
    @(posedge clk);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (hold_start) begin
        start = 1'b1;
        op_a  = ~a;
        op_b  = a;
        bin_init = ~bi;
      end else begin
        start = 1'b0;
      end
      chk({tag, "_run_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_run_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_cell_a"}, {31'd0, cell_a}, {31'd0, a[i]});
      chk({tag, "_cell_b"}, {31'd0, cell_b}, {31'd0, b[i]});
      chk({tag, "_cell_bin"}, {31'd0, cell_bin}, {31'd0, bw});
      chk({tag, "_held_res"}, {22'd0, last_res, last_bout, last_ovf},
          {22'd0, result, borrow_out, overflow});
      bw = (~a[i] & b[i]) | (~a[i] & bw) | (b[i] & bw);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_cells"}, {29'd0, cell_a, cell_b, cell_bin}, 32'd0);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
    chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp_bout});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    last_res  = exp_res;
    last_bout = exp_bout;
    last_ovf  = exp_ovf;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    bin_init  = 1'b0;
    last_res  = '0;
    last_bout = 1'b0;
    last_ovf  = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_result", {22'd0, result, borrow_out, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle");

    launch(8'd10, 8'd3, 1'b0);
    run_check("a10_b3", 8'd10, 8'd3, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle_outputs("post_done");
    chk("held_result", {24'd0, result}, 32'h07);

    launch(8'd3, 8'd10, 1'b0);
    run_check("a3_b10", 8'd3, 8'd10, 1'b0, 8'hF9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    launch(8'h00, 8'h00, 1'b1);
    run_check("zero_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    launch(8'h80, 8'h01, 1'b0);
    run_check("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    launch(8'h7F, 8'hFF, 1'b0);
    run_check("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

    // start held high through RUN with different operands must be ignored
    @(negedge clk);
    launch(8'h55, 8'h2A, 1'b1);
    run_check("hold", 8'h55, 8'h2A, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_idle_outputs("hold_idle");

    // Back-to-back: second start presented during the DONE cycle
    launch(8'h55, 8'h2A, 1'b1);
    run_check("b2b_1", 8'h55, 8'h2A, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
    launch(8'h10, 8'h20, 1'b0);
    run_check("b2b_2", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle_outputs("b2b_idle");

    // Asynchronous reset while bit 4 is on the cell
    launch(8'hC3, 8'h5A, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_cell_a", {31'd0, cell_a}, 32'd0);  // bit 4 of 0xC3
    chk("mid_cell_b", {31'd0, cell_b}, 32'd1);  // bit 4 of 0x5A
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_result", {22'd0, result, borrow_out, overflow}, 32'd0);
    last_res  = '0;
    last_bout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", {31'd0, done | busy}, 32'd0);
    end

    launch(8'hC3, 8'h5A, 1'b0);
    run_check("after_rst", 8'hC3, 8'h5A, 1'b0, 8'h69, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_sequencer.md
Name: serial_sub_sequencer

Overview:
- Bit-serial controller for the ALU's single-bit subtractor cell (diff/borrow_out from A, B, borrow_in).
- Computes a WIDTH-bit A − B − bin by driving the external cell LSB-first, one bit per clock.
- Registers each borrow for the next bit and assembles the result.
- Used where the ALU trades latency for area; it owns the start/busy/done handshake toward the ALU control logic.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
op_a  input  WIDTH  minuend, captured when start accepted
op_b  input  WIDTH  subtrahend, captured when start accepted
bin_init  input  1  initial borrow into bit 0, captured when start accepted
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  difference; held from DONE until next accepted start
borrow_out  output  1  final borrow from MSB; held like result
overflow  output  1  signed two's-complement overflow; held like result
cell_a  output  1  A bit to subtractor cell
cell_b  output  1  B bit to subtractor cell
cell_bin  output  1  borrow_in to subtractor cell
cell_diff  input  1  diff from cell (combinational in cell_a/b/bin)
cell_bout  input  1  borrow_out from cell

Behaviour:
- Decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (async, any state, including mid-RUN): state=IDLE; all internal registers are cleared.
  - Zero after reset: busy, done, result, borrow_out, overflow, cell_a, cell_b, cell_bin.
  - A partial computation is discarded; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs cell_* = 0.
  - On start=1: load the a_sh/b_sh shift registers from op_a/op_b.
  - Load borrow_reg=bin_init; latch a_msb=op_a[WIDTH-1] and b_msb=op_b[WIDTH-1].
  - Clear bit counter to 0; go to RUN.
- RUN:
  - busy=1.
  - Combinationally cell_a=a_sh[0], cell_b=b_sh[0], cell_bin=borrow_reg.
  - Each edge: shift cell_diff into the MSB of res_sh (shift right); borrow_reg<=cell_bout; shift a_sh and b_sh right; counter++.
  - After the edge processing bit WIDTH-1 (counter=WIDTH-1):
    - result<=assembled res_sh; borrow_out<=cell_bout.
    - overflow<=(a_msb^b_msb)&(a_msb^cell_diff).
    - Go to DONE.
  - start is ignored in RUN (no restart, no error).
- DONE:
  - done=1 for exactly one cycle; busy=0; cell_*=0.
  - Next edge: if start=1, accept as in IDLE (back-to-back permitted) and go to RUN; else go to IDLE.
- Latency:
  - The start-sampling edge is edge 0.
  - done is high in the cycle after edge WIDTH, i.e. 9 cycles from start to done for WIDTH=8.
  - Throughput is one op per WIDTH+1 cycles with back-to-back start.
- result, borrow_out and overflow change only on the DONE-entry edge or on reset. Mid-RUN they show the previous result.
- Arithmetic: result = (op_a − op_b − bin_init) mod 2^WIDTH; borrow_out=1 iff the unsigned op_a < op_b + bin_init.
- Counter width is clog2(WIDTH). No wrap-around beyond WIDTH−1.

Test Plan:
- op_a=10, op_b=3, bin_init=0, start 1 cycle -> busy high 8 cycles; done pulse 9 cycles after start; result=0x07, borrow_out=0, overflow=0.
- op_a=3, op_b=10 -> result=0xF9, borrow_out=1, overflow=0; for op_a=0x00, op_b=0x00, bin_init=1 -> result=0xFF, borrow_out=1.
- op_a=0x80, op_b=0x01 -> result=0x7F, borrow_out=0, overflow=1; op_a=0x7F, op_b=0xFF -> result=0x80, overflow=1, borrow_out=1.
- Back-to-back and busy-time start:
  - start held high through RUN with new operands -> ignored.
  - start held in the DONE cycle -> second op accepted; its done arrives 9 cycles after the first done.
- Reset mid-op: assert rst_n=0 asynchronously at bit 4 of a RUN -> all outputs 0 immediately, state IDLE, no done pulse.
  - Next start after release computes correctly.
- Cell protocol check: monitor cell_a/cell_b/cell_bin per RUN cycle against op bits LSB-first and a reference borrow chain; cell_* must be 0 outside RUN.
